// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised synchronous FIFO with optional first-word-fall-through and sticky error flags
module sync_fifo_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 2**ADDR_W-2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [DATA_W-1:0] D_in,
  input  logic              r_en,
  input  logic              err_clr,
  output logic [DATA_W-1:0] D_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] AF    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE    = (ADDR_W+1)'(AE_LEVEL);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] dout_q;
  logic [ADDR_W:0]   wptr, rptr, wptr_n, rptr_n;
  logic              do_w, do_r;
  assign full         = count == DEPTH;
  assign empty        = count == '0;
  assign almost_full  = count >= AF;
  assign almost_empty = count <= AE;
  assign do_w         = w_en & ~full;
  assign do_r         = r_en & ~empty;
  assign wptr_n       = wptr + (ADDR_W+1)'(do_w);
  assign rptr_n       = rptr + (ADDR_W+1)'(do_r);
  // occupancy is the pointer distance, so it stays consistent across wraps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      dout_q    <= '0;
    end else begin
      wptr      <= wptr_n;
      rptr      <= rptr_n;
      count     <= wptr_n - rptr_n;
      overflow  <= (w_en & full) | (overflow & ~err_clr);
      underflow <= (r_en & empty) | (underflow & ~err_clr);
      if (do_r) dout_q <= mem[rptr[ADDR_W-1:0]];
    end
  always_ff @(posedge clk)
    if (do_w) mem[wptr[ADDR_W-1:0]] <= D_in;
  assign D_out = (FWFT != 0) ? (empty ? '0 : mem[rptr[ADDR_W-1:0]]) : dout_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed scoreboard bench for standard and FWFT instances of sync_fifo_param
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  logic w_en = 0, r_en = 0, err_clr = 0;
  logic [15:0] D_in = '0, D_out;
  logic full, empty, af, ae, ovf, unf;
  logic [4:0] count;
  logic w_f = 0, r_f = 0, c_f = 0;
  logic [15:0] d_f = '0, q_f;
  logic full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [4:0] count_f;
  int n_cmp = 0, n_err = 0;
  logic [15:0] exp_q[$], exp_fq[$];

  sync_fifo_param #(.FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .D_in(D_in), .r_en(r_en), .err_clr(err_clr),
    .D_out(D_out), .full(full), .empty(empty), .almost_full(af), .almost_empty(ae),
    .count(count), .overflow(ovf), .underflow(unf));

  sync_fifo_param #(.FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .w_en(w_f), .D_in(d_f), .r_en(r_f), .err_clr(c_f),
    .D_out(q_f), .full(full_f), .empty(empty_f), .almost_full(af_f), .almost_empty(ae_f),
    .count(count_f), .overflow(ovf_f), .underflow(unf_f));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // standard mode: data appears one cycle after the accepted read edge
  always @(posedge clk) begin
    if (rst_n && r_en && !empty) begin
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_unexpected: got %0h expected no read", D_out);
      end else chk("rd_data", D_out, exp_q.pop_front());
    end
  end

  // FWFT mode: the word being consumed is already on D_out at the read edge
  always @(posedge clk) begin
    if (rst_n && r_f && !empty_f) begin
      if (exp_fq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL fwft_unexpected: got %0h expected no read", q_f);
      end else chk("fwft_data", q_f, exp_fq.pop_front());
    end
  end

  task automatic step(input logic w, input logic [15:0] d, input logic r, input logic c);
    w_en = w; D_in = d; r_en = r; err_clr = c;
    @(posedge clk); #2;
    w_en = 0; r_en = 0; err_clr = 0;
  endtask

  task automatic step_f(input logic w, input logic [15:0] d, input logic r);
    w_f = w; d_f = d; r_f = r;
    @(posedge clk); #2;
    w_f = 0; r_f = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_count", count, 5'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_ae", ae, 1'b1);
    chk("rst_af", af, 1'b0);
    chk("rst_flags", {ovf, unf}, 2'b00);
    chk("rst_dout", D_out, 16'h0);
    chk("rst_fwft_empty", empty_f, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    // fill 1..16 then drain in order
    for (int i = 1; i <= 16; i++) begin
      step(1, 16'(i), 0, 0);
      if (i == 2) chk("ae_at2", ae, 1'b1);
      if (i == 3) chk("ae_at3", ae, 1'b0);
      if (i == 13) chk("af_at13", af, 1'b0);
      if (i == 14) chk("af_at14", {af, full}, 2'b10);
      if (i == 15) chk("full_at15", full, 1'b0);
    end
    chk("full_at16", {full, empty, count}, {2'b10, 5'd16});
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(16'(i));
      step(0, 0, 1, 0);
    end
    chk("drained", {empty, count}, {1'b1, 5'd0});
    step(0, 0, 0, 0);
    chk("dout_hold", D_out, 16'h0010);
    // full with simultaneous read+write: read wins, write rejected
    for (int i = 1; i <= 16; i++) step(1, 16'(i), 0, 0);
    exp_q.push_back(16'h0001);
    step(1, 16'hBEEF, 1, 0);
    chk("ovf_count", count, 5'd15);
    chk("ovf_set", {ovf, unf, full}, 3'b100);
    for (int i = 2; i <= 16; i++) begin
      exp_q.push_back(16'(i));
      step(0, 0, 1, 0);
    end
    chk("ovf_drained", empty, 1'b1);
    // empty with simultaneous read+write: write wins
    step(1, 16'hA5A5, 1, 0);
    chk("unf_count", count, 5'd1);
    chk("unf_set", {ovf, unf}, 2'b11);
    exp_q.push_back(16'hA5A5);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("clr_set_wins", {ovf, unf}, 2'b01);
    step(0, 0, 0, 1);
    chk("clr_both", {ovf, unf}, 2'b00);
    // steady occupancy of 8 with streaming traffic across several wraps
    for (int i = 0; i < 8; i++) step(1, 16'h0100 + 16'(i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(16'h0100 + 16'(i));
      step(1, 16'h0108 + 16'(i), 1, 0);
      if (count !== 5'd8) chk("stream_count", count, 5'd8);
    end
    chk("stream_count_end", count, 5'd8);
    for (int i = 40; i < 48; i++) begin
      exp_q.push_back(16'h0100 + 16'(i));
      step(0, 0, 1, 0);
    end
    chk("stream_drained", {empty, ovf, unf}, 3'b100);
    // asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) step(1, 16'h0500 + 16'(i), 0, 0);
    chk("pre_rst_count", count, 5'd5);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {count, empty, full}, {5'd0, 2'b10});
    chk("async_rst_dout", D_out, 16'h0);
    @(negedge clk) rst_n = 1'b1;
    step(1, 16'h7777, 0, 0);
    exp_q.push_back(16'h7777);
    step(0, 0, 1, 0);
    chk("post_rst_empty", empty, 1'b1);
    // first-word-fall-through instance
    step_f(1, 16'h1234, 0);
    chk("fwft_show", {empty_f, q_f}, {1'b0, 16'h1234});
    step_f(1, 16'h5678, 0);
    chk("fwft_keep", q_f, 16'h1234);
    exp_fq.push_back(16'h1234);
    step_f(0, 0, 1);
    chk("fwft_next", {empty_f, q_f}, {1'b0, 16'h5678});
    exp_fq.push_back(16'h5678);
    step_f(0, 0, 1);
    chk("fwft_empty", {empty_f, count_f}, {1'b1, 5'd0});
    repeat (2) @(posedge clk);
    #2;
    chk("sb_left", exp_q.size(), 0);
    chk("sb_left_fwft", exp_fq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
